// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator datapath.
// Holds the multiplier FSM encoding and the iteration-counter sizing rule.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Counter must hold width-1; never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_wcarry_nbits.sv
// Parameterised ripple-carry adder with carry-in and separate carry-out.
// Purely combinational; one full-adder cell per bit.
module full_adder_wcarry_nbits #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             cin_i,
  output logic [width-1:0] s_o,
  output logic             cout_o
);

  always_comb begin
    logic carry;
    s_o   = '0;
    carry = cin_i;
    for (int unsigned i = 0; i < width; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_multiplier_nbits.sv
// Unsigned shift-and-add multiplier: width iterations through one ripple adder,
// registered 2*width-bit product updated only when an operation completes.
module seq_multiplier_nbits
  import calc_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [width-1:0]   a_i,
  input  logic [width-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*width-1:0] p_o
);

  localparam int unsigned CW = cnt_bits(width);

  mul_state_t         state_q, state_d;
  logic [width-1:0]   m_q, m_d;
  logic [width-1:0]   q_q, q_d;
  logic [width-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*width-1:0] p_q, p_d;
  logic               done_q, done_d;

  logic [width-1:0]   addend;
  logic [width-1:0]   sum;
  logic               carry;

  always_comb begin
    addend = q_q[0] ? m_q : '0;
  end

  full_adder_wcarry_nbits #(
    .width(width)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (addend),
    .cin_i (1'b0),
    .s_o   (sum),
    .cout_o(carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          acc_d   = '0;
          cnt_d   = CW'(width - 1);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Right shift of {carry, sum, Q}: carry enters ACC MSB, sum LSB enters Q MSB.
        acc_d = {carry, sum[width-1:1]};
        q_d   = {sum[0], q_q[width-1:1]};
        if (cnt_q == '0) begin
          p_d     = {acc_d, q_d};
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign p_o    = p_q;

endmodule

// File: tb/tb_seq_multiplier_nbits.sv
// Self-checking bench for seq_multiplier_nbits: directed table, random operands
// against a plain a*b model, and hand sequences for reset, restart and held start.
module tb_seq_multiplier_nbits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;
  logic        start2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [3:0]  p2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_multiplier_nbits #(.width(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .p_o(p8)
  );

  seq_multiplier_nbits #(.width(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2),
    .a_i(a2), .b_i(b2), .busy_o(busy2), .done_o(done2), .p_o(p2)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One isolated multiply on the width-8 instance; checks product and timing.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string name);
    logic [15:0] p_prev;
    int busy_cnt, done_cnt, done_at;
    bit held;
    @(negedge clk);
    p_prev = p8;
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    busy_cnt = 0; done_cnt = 0; done_at = -1; held = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < 8 && p8 !== p_prev) held = 1'b0;
    end
    check({name, ".product"}, p8, exp);
    check({name, ".busy_cycles"}, busy_cnt, 8);
    check({name, ".done_count"}, done_cnt, 1);
    check({name, ".done_cycle"}, done_at, 8);
    check({name, ".p_held_in_run"}, held, 1);
  endtask

  initial begin
    vec_t vecs[5];
    int done_cnt, busy_cnt, done_at;
    int dt[3];
    logic [15:0] dp[3];

    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd1,   8'd173, 16'd173};
    vecs[4] = '{8'd173, 8'd1,   16'd173};

    #12;
    check("reset.busy", busy8, 0);
    check("reset.done", done8, 0);
    check("reset.p", p8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      int unsigned model;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model = int'(ra) * int'(rb);
      run_op(ra, rb, model[15:0], $sformatf("rnd%0d", i));
    end

    // start toggled with other operands while running must be ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd6; b8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1 && k <= 5) start8 = k[0];
      else start8 = 1'b0;
      if (done8) done_cnt++;
    end
    check("ignore.product", p8, 42);
    check("ignore.done_count", done_cnt, 1);

    // reset in the middle of 200x3 after four iterations
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy8, 0);
    check("abort.done", done8, 0);
    check("abort.p", p8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) done_cnt++;
      if (busy8) busy_cnt++;
    end
    check("abort.no_done", done_cnt, 0);
    check("abort.no_busy", busy_cnt, 0);
    run_op(8'd5, 8'd5, 16'd25, "after_abort");

    // start held high across three back-to-back operations
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
    done_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) begin a8 = 8'd10; b8 = 8'd10; end
      if (k == 9) begin a8 = 8'd255; b8 = 8'd2; end
      if (k == 18) start8 = 1'b0;
      if (done8) begin
        if (done_cnt < 3) begin dt[done_cnt] = k; dp[done_cnt] = p8; end
        done_cnt++;
      end
    end
    check("b2b.done_count", done_cnt, 3);
    if (done_cnt >= 3) begin
      check("b2b.p0", dp[0], 12);
      check("b2b.p1", dp[1], 100);
      check("b2b.p2", dp[2], 510);
      check("b2b.first_done", dt[0], 8);
      check("b2b.space01", dt[1] - dt[0], 9);
      check("b2b.space12", dt[2] - dt[1], 9);
    end

    // minimum width instance
    @(negedge clk);
    start2 = 1'b1; a2 = 2'd3; b2 = 2'd3;
    @(negedge clk);
    start2 = 1'b0; a2 = 2'd1; b2 = 2'd2;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (busy2) busy_cnt++;
      if (done2) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    check("w2.product", p2, 9);
    check("w2.busy_cycles", busy_cnt, 2);
    check("w2.done_count", done_cnt, 1);
    check("w2.done_cycle", done_at, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
